reservation_station_mc: RTL and testbench
=========================================

RESERVATION_STATION_MC -- requirements
Module: reservation_station_mc

Interface
REQ-001 Parameter DEPTH, default 4: number of entries; any value 2..16.
REQ-002 Parameter ROB_WIDTH, default 3: ROB index width.
REQ-003 Parameter NUM_CDB, default 2: number of CDB broadcast ports snooped in parallel.
REQ-004 Parameter TAG_WIDTH, default 4: branch-tag mask width.
REQ-005 Parameter OP_WIDTH, default 2: FU opcode width.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst  in  1  reset; asynchronous, active-low.
REQ-008 disp_valid  in  1  dispatch request.
REQ-009 disp_rs1_ready, disp_rs2_ready  in  1 each  operand already holds a value.
REQ-010 disp_rs1_data, disp_rs2_data  in  32 each  value, or producer ROB index in bits [ROB_WIDTH-1:0].
REQ-011 disp_dest_rob  in  ROB_WIDTH  destination ROB entry.
REQ-012 disp_br_tag  in  TAG_WIDTH  speculation mask.
REQ-013 disp_op  in  OP_WIDTH  FU operation select.
REQ-014 rs_ready  out  1  at least one free entry.
REQ-015 occupancy  out  $clog2(DEPTH+1)  count of valid entries.
REQ-016 cdb_valid  in  NUM_CDB  per-port broadcast valid.
REQ-017 cdb_rob  in  NUM_CDB x ROB_WIDTH  per-port producer ROB index.
REQ-018 cdb_data  in  NUM_CDB x 32  per-port result.
REQ-019 flush  in  1  branch mispredict kill.
REQ-020 flush_mask  in  TAG_WIDTH  tag bits being killed.
REQ-021 fu_ready  in  1  FU can accept an operation this cycle.
REQ-022 issue_valid  out  1  operation presented to FU.
REQ-023 issue_op1, issue_op2  out  32 each  operands.
REQ-024 issue_dest_rob, issue_br_tag, issue_op  out  ROB_WIDTH/TAG_WIDTH/OP_WIDTH  issued entry fields.

Function
REQ-025 rs_ready and occupancy SHALL depend on registered entry-valid state only; no combinational path from fu_ready, cdb_* or flush.
REQ-026 disp_valid with rs_ready high SHALL write the lowest-index free entry at the clock edge; disp_valid with rs_ready low SHALL be ignored.
REQ-027 An operand not ready SHALL capture cdb_data[p] when cdb_valid[p] and cdb_rob[p] equals its tag; on multiple matches, the lowest p wins.
REQ-028 Dispatch-cycle bypass: a dispatched operand whose tag matches a valid CDB port in the same cycle SHALL be stored as ready with that data.
REQ-029 An entry SHALL be issue-eligible when valid and each operand is ready or matches a valid CDB port this cycle (same-cycle forwarding to issue_op1/op2).
REQ-030 issue_valid SHALL be high when fu_ready is high and at least one entry is eligible; the issued entry is freed at that edge (one issue per cycle).
REQ-031 Issue data outputs SHALL be don't-care when issue_valid is low.
REQ-032 flush SHALL invalidate, at the edge, every entry with (br_tag & flush_mask) != 0; such entries SHALL NOT assert issue_valid in the flush cycle.
REQ-033 A dispatch in a flush cycle whose disp_br_tag intersects flush_mask SHALL be discarded.
REQ-034 Surviving entries SHALL clear the flush_mask bits from their br_tag in the flush cycle.
REQ-035 Same-cycle dispatch and issue SHALL both complete; an entry freed by issue is not reusable until the next cycle.
REQ-036 occupancy SHALL equal the number of valid entries after each edge, never exceeding DEPTH.

Reset
REQ-037 rst low SHALL immediately clear all entry-valid bits and age state regardless of clk; outputs become rs_ready=1, occupancy=0, issue_valid=0.
REQ-038 Entry payload registers need not be reset.
REQ-039 Reset mid-operation SHALL discard all held entries with no issue after deassertion.

Configuration
REQ-040 Macro RS_AGE_ORDER_EN defined: SHALL maintain per-entry age ranking and issue the oldest eligible entry.
REQ-041 Macro RS_AGE_ORDER_EN undefined: SHALL issue the lowest-index eligible entry, with no age storage.

Verification
REQ-042 Reset, dispatch 4 ready ops (DEPTH=4), fu_ready=0 -> rs_ready=0 and occupancy=4; fifth disp_valid ignored.
REQ-043 Dispatch rs1 tag 5 unready; cdb_valid[1]=1, cdb_rob[1]=5, cdb_data[1]=0x1234, fu_ready=1 -> issue_valid same cycle, issue_op1=0x1234.
REQ-044 Dispatch with rs2 tag 3 while CDB broadcasts ROB 3 = 0xBEEF -> next cycle issue_op2=0xBEEF with no further CDB activity.
REQ-045 Entries tags 0b0001/0b0010/0b0011, flush_mask=0b0001 -> only the 0b0010 entry survives, now tagged 0b0010; occupancy=1.
REQ-046 With RS_AGE_ORDER_EN, dispatch A into entry 1 and then B into entry 0, both ready, fu_ready=1 -> A issues first; without macro -> B issues first.
REQ-047 rst low asserted between clock edges while entries valid -> issue_valid=0 and occupancy=0 immediately.

Source files
------------

// File: rtl/reservation_station_mc.sv
// reservation_station_mc: CDB-snooping reservation station with branch-tag flush and single issue per cycle.
// Define RS_AGE_ORDER_EN to issue the oldest eligible entry instead of the lowest-index one.
module reservation_station_mc #(
    parameter int DEPTH     = 4,
    parameter int ROB_WIDTH = 3,
    parameter int NUM_CDB   = 2,
    parameter int TAG_WIDTH = 4,
    parameter int OP_WIDTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         disp_valid_i,
    input  logic                         disp_rs1_ready_i,
    input  logic                         disp_rs2_ready_i,
    input  logic [31:0]                  disp_rs1_data_i,
    input  logic [31:0]                  disp_rs2_data_i,
    input  logic [ROB_WIDTH-1:0]         disp_dest_rob_i,
    input  logic [TAG_WIDTH-1:0]         disp_br_tag_i,
    input  logic [OP_WIDTH-1:0]          disp_op_i,
    output logic                         rs_ready_o,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
    input  logic [NUM_CDB-1:0]           cdb_valid_i,
    input  logic [NUM_CDB*ROB_WIDTH-1:0] cdb_rob_i,
    input  logic [NUM_CDB*32-1:0]        cdb_data_i,
    input  logic                         flush_i,
    input  logic [TAG_WIDTH-1:0]         flush_mask_i,
    input  logic                         fu_ready_i,
    output logic                         issue_valid_o,
    output logic [31:0]                  issue_op1_o,
    output logic [31:0]                  issue_op2_o,
    output logic [ROB_WIDTH-1:0]         issue_dest_rob_o,
    output logic [TAG_WIDTH-1:0]         issue_br_tag_o,
    output logic [OP_WIDTH-1:0]          issue_op_o
);
    localparam int IW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]     valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    logic [31:0]          op1_q [DEPTH], op1_d [DEPTH], op2_q [DEPTH], op2_d [DEPTH];
    logic [ROB_WIDTH-1:0] dest_q [DEPTH], dest_d [DEPTH];
    logic [TAG_WIDTH-1:0] tag_q [DEPTH], tag_d [DEPTH];
    logic [OP_WIDTH-1:0]  opc_q [DEPTH], opc_d [DEPTH];
    logic [DEPTH-1:0]     hit1, hit2, kill, elig, pick;
    logic [31:0]          fwd1 [DEPTH], fwd2 [DEPTH];
    logic [IW-1:0]        sel, free_idx;
    logic [OW-1:0]        occ;
    logic                 dh1, dh2, disp_fire;
    logic [31:0]          dd1, dd2;

    // Lowest-numbered matching CDB port wins; result is {hit, data}.
    function automatic logic [32:0] snoop(input logic [ROB_WIDTH-1:0] t,
                                          input logic [NUM_CDB-1:0] v,
                                          input logic [NUM_CDB*ROB_WIDTH-1:0] r,
                                          input logic [NUM_CDB*32-1:0] d);
        snoop = '0;
        for (int p = NUM_CDB-1; p >= 0; p--)
            if (v[p] && r[p*ROB_WIDTH +: ROB_WIDTH] == t) snoop = {1'b1, d[p*32 +: 32]};
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            {hit1[i], fwd1[i]} = snoop(op1_q[i][ROB_WIDTH-1:0], cdb_valid_i, cdb_rob_i, cdb_data_i);
            {hit2[i], fwd2[i]} = snoop(op2_q[i][ROB_WIDTH-1:0], cdb_valid_i, cdb_rob_i, cdb_data_i);
            kill[i] = flush_i && (tag_q[i] & flush_mask_i) != '0;
            elig[i] = valid_q[i] && !kill[i] && (rdy1_q[i] || hit1[i]) && (rdy2_q[i] || hit2[i]);
        end
        {dh1, dd1} = snoop(disp_rs1_data_i[ROB_WIDTH-1:0], cdb_valid_i, cdb_rob_i, cdb_data_i);
        {dh2, dd2} = snoop(disp_rs2_data_i[ROB_WIDTH-1:0], cdb_valid_i, cdb_rob_i, cdb_data_i);
    end

`ifdef RS_AGE_ORDER_EN
    // older_q[j][i] set means entry j was dispatched before entry i.
    logic [DEPTH-1:0] older_q [DEPTH], older_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            pick[i] = elig[i];
            for (int j = 0; j < DEPTH; j++)
                if (elig[j] && older_q[j][i]) pick[i] = 1'b0;
        end
    end

    always_comb begin
        older_d = older_q;
        if (disp_fire)
            for (int j = 0; j < DEPTH; j++) begin
                older_d[j][free_idx] = 1'b1;
                older_d[free_idx][j] = 1'b0;
            end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) older_q <= '{default: '0};
        else        older_q <= older_d;
`else
    assign pick = elig;
`endif

    always_comb begin
        sel      = '0;
        free_idx = '0;
        occ      = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (pick[i])     sel      = IW'(i);
            if (!valid_q[i]) free_idx = IW'(i);
            occ = occ + {{(OW-1){1'b0}}, valid_q[i]};
        end
    end

    assign rs_ready_o       = !(&valid_q);
    assign occupancy_o      = occ;
    assign disp_fire        = disp_valid_i && rs_ready_o && !(flush_i && (disp_br_tag_i & flush_mask_i) != '0);
    assign issue_valid_o    = fu_ready_i && |elig;
    assign issue_op1_o      = rdy1_q[sel] ? op1_q[sel] : fwd1[sel];
    assign issue_op2_o      = rdy2_q[sel] ? op2_q[sel] : fwd2[sel];
    assign issue_dest_rob_o = dest_q[sel];
    assign issue_br_tag_o   = tag_q[sel];
    assign issue_op_o       = opc_q[sel];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i] && !kill[i] && !(issue_valid_o && sel == IW'(i));
            rdy1_d[i]  = rdy1_q[i] || hit1[i];
            rdy2_d[i]  = rdy2_q[i] || hit2[i];
            op1_d[i]   = (!rdy1_q[i] && hit1[i]) ? fwd1[i] : op1_q[i];
            op2_d[i]   = (!rdy2_q[i] && hit2[i]) ? fwd2[i] : op2_q[i];
            tag_d[i]   = tag_q[i] & ~(flush_i ? flush_mask_i : '0);
            dest_d[i]  = dest_q[i];
            opc_d[i]   = opc_q[i];
            if (disp_fire && free_idx == IW'(i)) begin
                valid_d[i] = 1'b1;
                rdy1_d[i]  = disp_rs1_ready_i || dh1;
                rdy2_d[i]  = disp_rs2_ready_i || dh2;
                op1_d[i]   = (!disp_rs1_ready_i && dh1) ? dd1 : disp_rs1_data_i;
                op2_d[i]   = (!disp_rs2_ready_i && dh2) ? dd2 : disp_rs2_data_i;
                tag_d[i]   = disp_br_tag_i;
                dest_d[i]  = disp_dest_rob_i;
                opc_d[i]   = disp_op_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) valid_q <= '0;
        else        valid_q <= valid_d;

    always_ff @(posedge clk) begin
        rdy1_q <= rdy1_d;
        rdy2_q <= rdy2_d;
        op1_q  <= op1_d;
        op2_q  <= op2_d;
        tag_q  <= tag_d;
        dest_q <= dest_d;
        opc_q  <= opc_d;
    end
endmodule

// File: tb/tb_reservation_station_mc.sv
// tb_reservation_station_mc: directed vector table plus hand sequences for forwarding, flush, age and reset.
module tb_reservation_station_mc;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        disp_valid, r1rdy, r2rdy, flush, fu_ready;
    logic [31:0] d1, d2;
    logic [2:0]  dest;
    logic [3:0]  tag, mask;
    logic [1:0]  op;
    logic [1:0]  cdb_valid;
    logic [5:0]  cdb_rob;
    logic [63:0] cdb_data;
    logic        rs_ready, issue_valid;
    logic [2:0]  occupancy, issue_dest;
    logic [31:0] issue_op1, issue_op2;
    logic [3:0]  issue_tag;
    logic [1:0]  issue_op;
    int total = 0, bad = 0;

    reservation_station_mc dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid_i(disp_valid), .disp_rs1_ready_i(r1rdy), .disp_rs2_ready_i(r2rdy),
        .disp_rs1_data_i(d1), .disp_rs2_data_i(d2), .disp_dest_rob_i(dest),
        .disp_br_tag_i(tag), .disp_op_i(op),
        .rs_ready_o(rs_ready), .occupancy_o(occupancy),
        .cdb_valid_i(cdb_valid), .cdb_rob_i(cdb_rob), .cdb_data_i(cdb_data),
        .flush_i(flush), .flush_mask_i(mask), .fu_ready_i(fu_ready),
        .issue_valid_o(issue_valid), .issue_op1_o(issue_op1), .issue_op2_o(issue_op2),
        .issue_dest_rob_o(issue_dest), .issue_br_tag_o(issue_tag), .issue_op_o(issue_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dv;
        logic [31:0] a, b;
        logic [2:0]  dst;
        logic        fu;
        logic        e_iv;
        logic [31:0] e_op1, e_op2;
        logic [2:0]  e_dest;
        logic        e_rsr;
        logic [2:0]  e_occ;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle();
        disp_valid = 0; r1rdy = 0; r2rdy = 0; d1 = 0; d2 = 0; dest = 0; tag = 0; op = 0;
        cdb_valid = 0; cdb_rob = 0; cdb_data = 0; flush = 0; mask = 0; fu_ready = 0;
    endtask

    task automatic disp(input logic ra, input logic [31:0] a, input logic rb, input logic [31:0] b,
                        input logic [2:0] dst, input logic [3:0] t);
        disp_valid = 1; r1rdy = ra; d1 = a; r2rdy = rb; d2 = b; dest = dst; tag = t; op = 2'd1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{1, 32'h11, 32'h22, 3'd1, 0, 0, 0,      0,      0,    1, 3'd0};
        tbl[1]  = '{1, 32'h33, 32'h44, 3'd2, 0, 0, 0,      0,      0,    1, 3'd1};
        tbl[2]  = '{1, 32'h55, 32'h66, 3'd3, 0, 0, 0,      0,      0,    1, 3'd2};
        tbl[3]  = '{1, 32'h77, 32'h88, 3'd4, 0, 0, 0,      0,      0,    1, 3'd3};
        tbl[4]  = '{1, 32'hE1, 32'hE2, 3'd5, 0, 0, 0,      0,      0,    0, 3'd4};
        tbl[5]  = '{0, 0,      0,      3'd0, 1, 1, 32'h11, 32'h22, 3'd1, 0, 3'd4};
        tbl[6]  = '{1, 32'h99, 32'hAA, 3'd6, 1, 1, 32'h33, 32'h44, 3'd2, 1, 3'd3};
        tbl[7]  = '{0, 0,      0,      3'd0, 1, 1, 32'h99, 32'hAA, 3'd6, 1, 3'd3};
        tbl[8]  = '{0, 0,      0,      3'd0, 1, 1, 32'h55, 32'h66, 3'd3, 1, 3'd2};
        tbl[9]  = '{0, 0,      0,      3'd0, 1, 1, 32'h77, 32'h88, 3'd4, 1, 3'd1};
        tbl[10] = '{0, 0,      0,      3'd0, 1, 0, 0,      0,      0,    1, 3'd0};
        idle();
        fu_ready = 1;
        #12 rst_n = 1;
        #1;
        chk("reset_occ", 32'(occupancy), 0);
        chk("reset_rs_ready", 32'(rs_ready), 1);
        chk("reset_issue_valid", 32'(issue_valid), 0);

        for (int i = 0; i < 11; i++) begin
            cyc();
            idle();
            if (tbl[i].dv) disp(1, tbl[i].a, 1, tbl[i].b, tbl[i].dst, 4'd0);
            fu_ready = tbl[i].fu;
            #4;
            chk($sformatf("v%0d_rs_ready", i), 32'(rs_ready), 32'(tbl[i].e_rsr));
            chk($sformatf("v%0d_occ", i), 32'(occupancy), 32'(tbl[i].e_occ));
            chk($sformatf("v%0d_issue_valid", i), 32'(issue_valid), 32'(tbl[i].e_iv));
            if (tbl[i].e_iv) begin
                chk($sformatf("v%0d_op1", i), issue_op1, tbl[i].e_op1);
                chk($sformatf("v%0d_op2", i), issue_op2, tbl[i].e_op2);
                chk($sformatf("v%0d_dest", i), 32'(issue_dest), 32'(tbl[i].e_dest));
            end
        end

        // Unready rs1 waits for tag 5, then forwards from CDB port 1 in the issue cycle.
        cyc(); idle(); disp(0, 32'd5, 1, 32'd2, 3'd1, 4'd0); #4;
        cyc(); idle(); fu_ready = 1; #4;
        chk("unready_hold", 32'(issue_valid), 0);
        cyc(); idle(); fu_ready = 1; cdb_valid = 2'b10; cdb_rob = {3'd5, 3'd0};
        cdb_data = {32'h1234, 32'h0}; #4;
        chk("fwd_issue_valid", 32'(issue_valid), 1);
        chk("fwd_op1", issue_op1, 32'h1234);
        chk("fwd_op2", issue_op2, 32'h2);

        // Both ports match: port 0 must win.
        cyc(); idle(); disp(0, 32'd2, 1, 32'd7, 3'd2, 4'd0); #4;
        cyc(); idle(); fu_ready = 1; cdb_valid = 2'b11; cdb_rob = {3'd2, 3'd2};
        cdb_data = {32'hBBBB, 32'hAAAA}; #4;
        chk("prio_issue_valid", 32'(issue_valid), 1);
        chk("prio_op1", issue_op1, 32'hAAAA);

        // Dispatch-cycle bypass is captured and used later without CDB activity.
        cyc(); idle(); disp(1, 32'd1, 0, 32'd3, 3'd3, 4'd0); cdb_valid = 2'b01;
        cdb_rob = {3'd0, 3'd3}; cdb_data = {32'h0, 32'hBEEF}; #4;
        cyc(); idle(); fu_ready = 1; #4;
        chk("bypass_issue_valid", 32'(issue_valid), 1);
        chk("bypass_op2", issue_op2, 32'hBEEF);
        chk("bypass_op1", issue_op1, 32'h1);

        // Flush with mask 0001 over tags 0001/0010/0011.
        cyc(); idle(); disp(1, 1, 1, 1, 3'd1, 4'b0001); #4;
        cyc(); idle(); disp(1, 2, 1, 2, 3'd2, 4'b0010); #4;
        cyc(); idle(); disp(1, 3, 1, 3, 3'd3, 4'b0011); #4;
        cyc(); idle(); flush = 1; mask = 4'b0001; #4;
        cyc(); idle(); #4;
        chk("flush_occ", 32'(occupancy), 1);
        cyc(); idle(); fu_ready = 1; #4;
        chk("flush_survivor_valid", 32'(issue_valid), 1);
        chk("flush_survivor_dest", 32'(issue_dest), 2);
        chk("flush_survivor_tag", 32'(issue_tag), 32'b0010);

        // Killed entry must not issue in the flush cycle; intersecting dispatch is dropped.
        cyc(); idle(); disp(1, 4, 1, 4, 3'd4, 4'b0001); #4;
        cyc(); idle(); disp(1, 5, 1, 5, 3'd5, 4'b0011); fu_ready = 1; flush = 1; mask = 4'b0001; #4;
        chk("kill_no_issue", 32'(issue_valid), 0);
        cyc(); idle(); disp(1, 6, 1, 6, 3'd6, 4'b0100); flush = 1; mask = 4'b0001; #4;
        chk("kill_occ", 32'(occupancy), 0);
        cyc(); idle(); fu_ready = 1; #4;
        chk("flush_keep_disp_valid", 32'(issue_valid), 1);
        chk("flush_keep_disp_tag", 32'(issue_tag), 32'b0100);

        // A lands in entry 1, B later in entry 0.
        cyc(); idle(); disp(1, 7, 1, 7, 3'd7, 4'b1000); #4;
        cyc(); idle(); disp(1, 8, 1, 8, 3'd1, 4'b0000); #4;
        cyc(); idle(); flush = 1; mask = 4'b1000; #4;
        cyc(); idle(); disp(1, 9, 1, 9, 3'd2, 4'b0000); #4;
        cyc(); idle(); fu_ready = 1; #4;
        chk("age_issue_valid", 32'(issue_valid), 1);
`ifdef RS_AGE_ORDER_EN
        chk("age_first_dest", 32'(issue_dest), 1);
`else
        chk("age_first_dest", 32'(issue_dest), 2);
`endif

        // Asynchronous reset between edges.
        cyc(); idle(); disp(1, 10, 1, 10, 3'd3, 4'b0000); #4;
        cyc(); idle(); fu_ready = 1;
        #1 chk("pre_reset_issue_valid", 32'(issue_valid), 1);
        #1 rst_n = 0;
        #1;
        chk("async_reset_issue_valid", 32'(issue_valid), 0);
        chk("async_reset_occ", 32'(occupancy), 0);
        chk("async_reset_rs_ready", 32'(rs_ready), 1);
        #1 rst_n = 1;
        cyc(); idle(); fu_ready = 1; #4;
        chk("post_reset_issue_valid", 32'(issue_valid), 0);
        chk("post_reset_occ", 32'(occupancy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
